div_sqrt_arbiter_mvp: RTL and testbench

Round-robin arbiter and sequencer that shares one div_sqrt_top_mvp core between NUM_REQ requesters (e.g. several FPU lanes or cores). Accepts one request at a time and latches its operands and controls. Pulses the core's div or sqrt start, waits for done, and returns result and flags to the owning requester over a valid/ready response. Sits between the requester ports and the core.

---
 rtl/div_sqrt_arbiter_mvp_if.sv | 49 ++++
 rtl/div_sqrt_arbiter_mvp.sv | 225 ++++++++++++++++++++++
 tb/tb_div_sqrt_arbiter_mvp.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_sqrt_arbiter_mvp_if.sv
// Bundles requester, core and response signals of the div/sqrt arbiter.
// slave: arbiter view; master: view of the surrounding requesters and core.
interface div_sqrt_arbiter_mvp_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    Req_Valid_SI;
  logic [NUM_REQ-1:0]    Req_Ready_SO;
  logic [NUM_REQ-1:0]    Req_Sqrt_SI;
  logic [NUM_REQ*64-1:0] Req_Operand_a_DI;
  logic [NUM_REQ*64-1:0] Req_Operand_b_DI;
  logic [NUM_REQ*3-1:0]  Req_RM_DI;
  logic [NUM_REQ*2-1:0]  Req_Format_sel_DI;
  logic [NUM_REQ*6-1:0]  Req_Precision_ctl_DI;
  logic                  Core_Div_start_SO;
  logic                  Core_Sqrt_start_SO;
  logic [63:0]           Core_Operand_a_DO;
  logic [63:0]           Core_Operand_b_DO;
  logic [2:0]            Core_RM_SO;
  logic [1:0]            Core_Format_sel_SO;
  logic [5:0]            Core_Precision_ctl_SO;
  logic                  Core_Done_SI;
  logic [63:0]           Core_Result_DI;
  logic [4:0]            Core_Fflags_SI;
  logic [NUM_REQ-1:0]    Resp_Valid_SO;
  logic [NUM_REQ-1:0]    Resp_Ready_SI;
  logic [63:0]           Resp_Result_DO;
  logic [4:0]            Resp_Fflags_DO;
  logic                  Busy_SO;

  modport slave (
    input  Req_Valid_SI, Req_Sqrt_SI, Req_Operand_a_DI, Req_Operand_b_DI,
           Req_RM_DI, Req_Format_sel_DI, Req_Precision_ctl_DI,
           Core_Done_SI, Core_Result_DI, Core_Fflags_SI, Resp_Ready_SI,
    output Req_Ready_SO, Core_Div_start_SO, Core_Sqrt_start_SO,
           Core_Operand_a_DO, Core_Operand_b_DO, Core_RM_SO, Core_Format_sel_SO,
           Core_Precision_ctl_SO, Resp_Valid_SO, Resp_Result_DO, Resp_Fflags_DO,
           Busy_SO
  );

  modport master (
    output Req_Valid_SI, Req_Sqrt_SI, Req_Operand_a_DI, Req_Operand_b_DI,
           Req_RM_DI, Req_Format_sel_DI, Req_Precision_ctl_DI,
           Core_Done_SI, Core_Result_DI, Core_Fflags_SI, Resp_Ready_SI,
    input  Req_Ready_SO, Core_Div_start_SO, Core_Sqrt_start_SO,
           Core_Operand_a_DO, Core_Operand_b_DO, Core_RM_SO, Core_Format_sel_SO,
           Core_Precision_ctl_SO, Resp_Valid_SO, Resp_Result_DO, Resp_Fflags_DO,
           Busy_SO
  );
endinterface

// File: rtl/div_sqrt_arbiter_mvp.sv
// Round-robin arbiter/sequencer sharing one div/sqrt core between NUM_REQ requesters.
// Defining DIV_SQRT_ARB_TIMEOUT_EN adds a BUSY watchdog and the Timeout_SO port.
module div_sqrt_arbiter_mvp #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic Clk_CI,
  input  logic Rst_RBI,
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  output logic Timeout_SO,
`endif
  div_sqrt_arbiter_mvp_if.slave bus
);
  localparam int C_RM = 3;
  localparam int C_FS = 2;
  localparam int C_PC = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                sqrt_q, sqrt_d;
  logic [63:0]         opa_q, opa_d;
  logic [63:0]         opb_q, opb_d;
  logic [C_RM-1:0]     rm_q, rm_d;
  logic [C_FS-1:0]     fs_q, fs_d;
  logic [C_PC-1:0]     pc_q, pc_d;
  logic [63:0]         res_q, res_d;
  logic [4:0]          ffl_q, ffl_d;
  logic                div_start_q, div_start_d;
  logic                sqrt_start_q, sqrt_start_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  resp_vld_q, resp_vld_d;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic                gnt_vld_s;
  logic [ID_W-1:0]     gnt_id_s;
  logic [ID_W:0]       sum_s;
  logic [ID_W:0]       idx_s;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  logic [6:0]          to_cnt_q, to_cnt_d;
  logic                timeout_q, timeout_d;
`endif

  logic [63:0]     opa_arr_s [NUM_REQ];
  logic [63:0]     opb_arr_s [NUM_REQ];
  logic [C_RM-1:0] rm_arr_s  [NUM_REQ];
  logic [C_FS-1:0] fs_arr_s  [NUM_REQ];
  logic [C_PC-1:0] pc_arr_s  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign opa_arr_s[gi] = bus.Req_Operand_a_DI[64*gi +: 64];
    assign opb_arr_s[gi] = bus.Req_Operand_b_DI[64*gi +: 64];
    assign rm_arr_s[gi]  = bus.Req_RM_DI[C_RM*gi +: C_RM];
    assign fs_arr_s[gi]  = bus.Req_Format_sel_DI[C_FS*gi +: C_FS];
    assign pc_arr_s[gi]  = bus.Req_Precision_ctl_DI[C_PC*gi +: C_PC];
  end

  // Scan downwards so the closest valid requester after the pointer is the last one written.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = '0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_s     = {1'b0, ptr_q} + (ID_W+1)'(k);
      idx_s     = (sum_s >= (ID_W+1)'(NUM_REQ)) ? (sum_s - (ID_W+1)'(NUM_REQ)) : sum_s;
      gnt_vld_s = gnt_vld_s | bus.Req_Valid_SI[idx_s[ID_W-1:0]];
      gnt_id_s  = bus.Req_Valid_SI[idx_s[ID_W-1:0]] ? idx_s[ID_W-1:0] : gnt_id_s;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    sqrt_d       = sqrt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rm_d         = rm_q;
    fs_d         = fs_q;
    pc_d         = pc_q;
    res_d        = res_q;
    ffl_d        = ffl_q;
    resp_vld_d   = resp_vld_q;
    div_start_d  = 1'b0;
    sqrt_start_d = 1'b0;
    req_ready_s  = '0;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld_s) begin
          req_ready_s[gnt_id_s] = 1'b1;
          id_d         = gnt_id_s;
          sqrt_d       = bus.Req_Sqrt_SI[gnt_id_s];
          opa_d        = opa_arr_s[gnt_id_s];
          opb_d        = opb_arr_s[gnt_id_s];
          rm_d         = rm_arr_s[gnt_id_s];
          fs_d         = fs_arr_s[gnt_id_s];
          pc_d         = pc_arr_s[gnt_id_s];
          ptr_d        = (gnt_id_s == ID_W'(NUM_REQ - 1)) ? '0 : (gnt_id_s + ID_W'(1));
          div_start_d  = ~bus.Req_Sqrt_SI[gnt_id_s];
          sqrt_start_d = bus.Req_Sqrt_SI[gnt_id_s];
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
        to_cnt_d = 7'd0;
`endif
        state_d = BUSY;
      end
      BUSY: begin
        // Done takes priority over the watchdog when both land in the same cycle.
        if (bus.Core_Done_SI) begin
          res_d             = bus.Core_Result_DI;
          ffl_d             = bus.Core_Fflags_SI;
          resp_vld_d        = '0;
          resp_vld_d[id_q]  = 1'b1;
          state_d           = RESP;
        end
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
        else if (to_cnt_q == 7'd99) begin
          res_d             = 64'h7FF8_0000_0000_0000;
          ffl_d             = 5'b10000;
          resp_vld_d        = '0;
          resp_vld_d[id_q]  = 1'b1;
          timeout_d         = 1'b1;
          state_d           = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 7'd1;
          state_d  = BUSY;
        end
`else
        else begin
          state_d = BUSY;
        end
`endif
      end
      RESP: begin
        if (bus.Resp_Ready_SI[id_q]) begin
          resp_vld_d = '0;
          state_d    = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        resp_vld_d = '0;
        state_d    = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      sqrt_q       <= 1'b0;
      opa_q        <= 64'd0;
      opb_q        <= 64'd0;
      rm_q         <= '0;
      fs_q         <= '0;
      pc_q         <= '0;
      res_q        <= 64'd0;
      ffl_q        <= 5'd0;
      resp_vld_q   <= '0;
      div_start_q  <= 1'b0;
      sqrt_start_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
      to_cnt_q     <= 7'd0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      sqrt_q       <= sqrt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rm_q         <= rm_d;
      fs_q         <= fs_d;
      pc_q         <= pc_d;
      res_q        <= res_d;
      ffl_q        <= ffl_d;
      resp_vld_q   <= resp_vld_d;
      div_start_q  <= div_start_d;
      sqrt_start_q <= sqrt_start_d;
      busy_q       <= busy_d;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus.Req_Ready_SO          = req_ready_s;
  assign bus.Core_Div_start_SO     = div_start_q;
  assign bus.Core_Sqrt_start_SO    = sqrt_start_q;
  assign bus.Core_Operand_a_DO     = opa_q;
  assign bus.Core_Operand_b_DO     = opb_q;
  assign bus.Core_RM_SO            = rm_q;
  assign bus.Core_Format_sel_SO    = fs_q;
  assign bus.Core_Precision_ctl_SO = pc_q;
  assign bus.Resp_Valid_SO         = resp_vld_q;
  assign bus.Resp_Result_DO        = res_q;
  assign bus.Resp_Fflags_DO        = ffl_q;
  assign bus.Busy_SO               = busy_q;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  assign Timeout_SO                = timeout_q;
`endif
endmodule

// File: tb/tb_div_sqrt_arbiter_mvp.sv
// Self-checking bench for div_sqrt_arbiter_mvp: random requests against a round-robin
// reference model, with a behavioural core that answers after a chosen latency.
`timescale 1ns/1ps
module tb_div_sqrt_arbiter_mvp;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_sqrt_arbiter_mvp_if #(.NUM_REQ(NR)) bus ();
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  logic timeout;
`endif

  div_sqrt_arbiter_mvp #(.NUM_REQ(NR)) dut (
    .Clk_CI  (clk),
    .Rst_RBI (rst_n),
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    .Timeout_SO (timeout),
`endif
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Requester-side model state.
  logic        r_valid [NR];
  logic        r_sqrt  [NR];
  logic [63:0] r_a     [NR];
  logic [63:0] r_b     [NR];
  logic [2:0]  r_rm    [NR];
  logic [1:0]  r_fs    [NR];
  logic [5:0]  r_pc    [NR];
  int          rem     [NR];
  int          m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.Req_Valid_SI[i]                = r_valid[i];
      bus.Req_Sqrt_SI[i]                 = r_sqrt[i];
      bus.Req_Operand_a_DI[64*i +: 64]   = r_a[i];
      bus.Req_Operand_b_DI[64*i +: 64]   = r_b[i];
      bus.Req_RM_DI[3*i +: 3]            = r_rm[i];
      bus.Req_Format_sel_DI[2*i +: 2]    = r_fs[i];
      bus.Req_Precision_ctl_DI[6*i +: 6] = r_pc[i];
    end
  endtask

  task automatic new_req(input int i);
    r_valid[i] = 1'b1;
    r_sqrt[i]  = 1'($urandom_range(0, 1));
    r_a[i]     = {$urandom, $urandom};
    r_b[i]     = {$urandom, $urandom};
    r_rm[i]    = 3'($urandom_range(0, 4));
    r_fs[i]    = 2'($urandom_range(0, 3));
    r_pc[i]    = 6'($urandom_range(0, 63));
  endtask

  // Requester i has been accepted: present its next op or drop valid.
  task automatic refresh(input int i);
    rem[i]--;
    if (rem[i] > 0) new_req(i);
    else r_valid[i] = 1'b0;
    drive();
  endtask

  // Winner = valid requester with the smallest forward distance from the pointer.
  function automatic int model_grant();
    int best = -1;
    int bestd = NR;
    for (int i = 0; i < NR; i++) begin
      if (r_valid[i] && (((i - m_ptr + NR) % NR) < bestd)) begin
        bestd = (i - m_ptr + NR) % NR;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"},  64'(bus.Req_Ready_SO), 64'd0);
    chk({tag, "_starts"}, 64'({bus.Core_Div_start_SO, bus.Core_Sqrt_start_SO}), 64'd0);
    chk({tag, "_opa"},    bus.Core_Operand_a_DO, 64'd0);
    chk({tag, "_opb"},    bus.Core_Operand_b_DO, 64'd0);
    chk({tag, "_ctl"},    64'({bus.Core_RM_SO, bus.Core_Format_sel_SO, bus.Core_Precision_ctl_SO}), 64'd0);
    chk({tag, "_rvalid"}, 64'(bus.Resp_Valid_SO), 64'd0);
    chk({tag, "_result"}, bus.Resp_Result_DO, 64'd0);
    chk({tag, "_fflags"}, 64'(bus.Resp_Fflags_DO), 64'd0);
    chk({tag, "_busy"},   64'(bus.Busy_SO), 64'd0);
  endtask

  // One full operation from an IDLE cycle (called at negedge+ with requests settled).
  task automatic txn(input int lat, input int bp, input bit spur);
    int g;
    logic [NR-1:0] oh;
    logic          e_sqrt;
    logic [63:0]   ea, eb, res;
    logic [2:0]    erm;
    logic [1:0]    efs;
    logic [5:0]    epc;
    logic [4:0]    ffl;
    g = model_grant();
    if (g < 0) return;
    oh = '0;
    oh[g] = 1'b1;
    chk("req_ready_grant", 64'(bus.Req_Ready_SO), 64'(oh));
    chk("busy_idle", 64'(bus.Busy_SO), 64'd0);
    e_sqrt = r_sqrt[g]; ea = r_a[g]; eb = r_b[g]; erm = r_rm[g]; efs = r_fs[g]; epc = r_pc[g];
    @(negedge clk);
    m_ptr = (g + 1) % NR;
    refresh(g);
    if (spur) begin
      bus.Core_Done_SI   = 1'b1;
      bus.Core_Result_DI = {$urandom, $urandom};
    end
    #1;
    chk("div_start", 64'(bus.Core_Div_start_SO), 64'(!e_sqrt));
    chk("sqrt_start", 64'(bus.Core_Sqrt_start_SO), 64'(e_sqrt));
    chk("req_ready_issue", 64'(bus.Req_Ready_SO), 64'd0);
    chk("busy_issue", 64'(bus.Busy_SO), 64'd1);
    chk("core_a", bus.Core_Operand_a_DO, ea);
    chk("core_b", bus.Core_Operand_b_DO, eb);
    chk("core_ctl", 64'({bus.Core_RM_SO, bus.Core_Format_sel_SO, bus.Core_Precision_ctl_SO}),
        64'({erm, efs, epc}));
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      bus.Core_Done_SI = 1'b0;
      #1;
      chk("starts_busy", 64'({bus.Core_Div_start_SO, bus.Core_Sqrt_start_SO}), 64'd0);
      chk("rvalid_busy", 64'(bus.Resp_Valid_SO), 64'd0);
      chk("req_ready_busy", 64'(bus.Req_Ready_SO), 64'd0);
    end
    @(negedge clk);
    res = {$urandom, $urandom};
    ffl = 5'($urandom_range(0, 31));
    bus.Core_Done_SI   = 1'b1;
    bus.Core_Result_DI = res;
    bus.Core_Fflags_SI = ffl;
    #1;
    chk("rvalid_done_cycle", 64'(bus.Resp_Valid_SO), 64'd0);
    @(negedge clk);
    bus.Core_Done_SI   = 1'b0;
    bus.Core_Result_DI = ~res;
    bus.Core_Fflags_SI = ~ffl;
    #1;
    chk("rvalid_resp", 64'(bus.Resp_Valid_SO), 64'(oh));
    chk("result", bus.Resp_Result_DO, res);
    chk("fflags", 64'(bus.Resp_Fflags_DO), 64'(ffl));
    chk("req_ready_resp", 64'(bus.Req_Ready_SO), 64'd0);
    chk("core_b_resp", bus.Core_Operand_b_DO, eb);
    for (int c = 0; c < bp; c++) begin
      bus.Resp_Ready_SI = ~oh;
      if (c == 0) bus.Core_Done_SI = 1'b1;
      @(negedge clk);
      bus.Core_Done_SI = 1'b0;
      #1;
      chk("rvalid_hold", 64'(bus.Resp_Valid_SO), 64'(oh));
      chk("result_hold", bus.Resp_Result_DO, res);
      chk("fflags_hold", 64'(bus.Resp_Fflags_DO), 64'(ffl));
      chk("req_ready_hold", 64'(bus.Req_Ready_SO), 64'd0);
      chk("core_b_hold", bus.Core_Operand_b_DO, eb);
    end
    bus.Resp_Ready_SI = oh;
    @(negedge clk);
    bus.Resp_Ready_SI = '0;
    #1;
    chk("rvalid_after", 64'(bus.Resp_Valid_SO), 64'd0);
    chk("busy_after", 64'(bus.Busy_SO), 64'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin
      r_valid[i] = 1'b0; r_sqrt[i] = 1'b0; r_a[i] = 64'd0; r_b[i] = 64'd0;
      r_rm[i] = 3'd0; r_fs[i] = 2'd0; r_pc[i] = 6'd0; rem[i] = 0;
    end
    m_ptr = 0;
    bus.Core_Done_SI   = 1'b0;
    bus.Core_Result_DI = 64'd0;
    bus.Core_Fflags_SI = 5'd0;
    bus.Resp_Ready_SI  = '0;
    drive();

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed div from requester 0: 2.0 / 1.0, format 01, RM 000.
    r_valid[0] = 1'b1; r_sqrt[0] = 1'b0; r_a[0] = 64'h4000_0000_0000_0000;
    r_b[0] = 64'h3FF0_0000_0000_0000; r_rm[0] = 3'd0; r_fs[0] = 2'b01; r_pc[0] = 6'd0;
    rem[0] = 1;
    drive();
    #1;
    txn(5, 0, 1'b0);

    // No requests: stays idle.
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("idle_ready", 64'(bus.Req_Ready_SO), 64'd0);
      chk("idle_busy", 64'(bus.Busy_SO), 64'd0);
    end

    // Requesters 0 and 1 continuously valid, three ops each: alternating grants.
    new_req(0); new_req(1); rem[0] = 3; rem[1] = 3;
    drive();
    #1;
    repeat (6) txn($urandom_range(1, 8), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    // Directed sqrt from requester 1 with a recognisable B.
    new_req(1); r_sqrt[1] = 1'b1; r_b[1] = 64'hDEAD_BEEF_DEAD_BEEF; rem[1] = 1;
    drive();
    #1;
    txn(4, 3, 1'b0);

    // Response backpressure for 10 cycles while requester 0 keeps requesting.
    new_req(0); rem[0] = 2;
    drive();
    #1;
    txn(3, 10, 1'b1);
    txn(2, 0, 1'b0);

    // Random traffic on all requesters.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NR; i++) begin
        if (!r_valid[i] && ($urandom_range(0, 1) == 1)) begin
          new_req(i);
          rem[i] = $urandom_range(1, 3);
        end
      end
      if (model_grant() < 0) begin
        new_req(it % NR);
        rem[it % NR] = 1;
      end
      drive();
      #1;
      txn($urandom_range(1, 12), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    for (int d = 0; d < 40 && model_grant() >= 0; d++) begin
      drive();
      #1;
      txn($urandom_range(1, 6), $urandom_range(0, 2), 1'b0);
    end

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    // Core never answers: watchdog fires after 100 BUSY cycles.
    new_req(2); rem[2] = 1;
    drive();
    #1;
    chk("to_grant", 64'(bus.Req_Ready_SO), 64'h4);
    @(negedge clk);
    m_ptr = 0;
    refresh(2);
    n = 0;
    while (n < 150 && timeout !== 1'b1) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("to_cycles", 64'(n), 64'd101);
    chk("to_result", bus.Resp_Result_DO, 64'h7FF8_0000_0000_0000);
    chk("to_fflags", 64'(bus.Resp_Fflags_DO), 64'h10);
    chk("to_rvalid", 64'(bus.Resp_Valid_SO), 64'h4);
    @(negedge clk);
    #1;
    chk("to_pulse_end", 64'(timeout), 64'd0);
    bus.Resp_Ready_SI = 3'b100;
    @(negedge clk);
    bus.Resp_Ready_SI = '0;
    #1;
    chk("to_busy_after", 64'(bus.Busy_SO), 64'd0);
`endif

    // Reset during BUSY, then a stale Done after release.
    new_req(0); rem[0] = 1;
    drive();
    #1;
    chk("abort_grant", 64'(bus.Req_Ready_SO), 64'(64'd1 << model_grant()));
    @(negedge clk);
    r_valid[0] = 1'b0; rem[0] = 0;
    drive();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_busy");
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    bus.Core_Done_SI   = 1'b1;
    bus.Core_Result_DI = 64'h1234_5678_9ABC_DEF0;
    bus.Core_Fflags_SI = 5'h1F;
    @(negedge clk);
    bus.Core_Done_SI = 1'b0;
    #1;
    chk_zero("stale_done");
    new_req(0); new_req(1); rem[0] = 1; rem[1] = 1;
    drive();
    #1;
    chk("rst_ptr_grant", 64'(bus.Req_Ready_SO), 64'd1);
    txn(3, 1, 1'b0);
    txn(2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
